// File: rtl/add_apx_pipe.sv
// Pipelined approximate adder: lower-part OR on APPROX_BITS LSBs, exact segmented ripple above; ADD_APX_ERRMON_EN adds an error monitor.
// Latency PIPE_STAGES cycles; combinational ready chain (no skid), outputs hold while stalled.
module add_apx_pipe #(
    parameter int WIDTH       = 8,
    parameter int APPROX_BITS = 2,
    parameter int PIPE_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_apx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    output logic             out_apx
`ifdef ADD_APX_ERRMON_EN
    ,
    input  logic             errmon_clr,
    output logic [WIDTH:0]   err_max,
    output logic [31:0]      err_cnt
`endif
);

    localparam int K    = APPROX_BITS;
    localparam int S    = PIPE_STAGES;
    localparam int U    = WIDTH - K;
    localparam int BASE = U / S;

    logic [S-1:0] vld_vec;
    logic [S-1:0] adv;

    for (genvar s = 0; s < S; s++) begin : g_st
        localparam int LO = K + s * BASE;
        localparam int W  = (s == S-1) ? (U - BASE * (S-1)) : BASE;
        localparam int SW = (s == S-1) ? (WIDTH + 1) : (LO + W);

        logic [WIDTH-LO-1:0] op_a;
        logic [WIDTH-LO-1:0] op_b;
        logic                v_in;
        logic                apx_in;
        logic                seg_ci;
        logic [W:0]          seg;
        logic [SW-1:0]       sum_d;
        logic [SW-1:0]       sum_q;
        logic                vld_q;
        logic                apx_q;
`ifdef ADD_APX_ERRMON_EN
        logic [WIDTH:0]      ex_d;
        logic [WIDTH:0]      ex_q;
`endif

        // A stage moves if it or any slot downstream is empty, or the sink takes a beat.
        assign adv[s]     = out_ready | ~(&vld_vec[S-1:s]);
        assign vld_vec[s] = vld_q;
        assign seg        = {1'b0, op_a[W-1:0]} + {1'b0, op_b[W-1:0]} + (W+1)'(seg_ci);

        if (s == 0) begin : g_head
            assign v_in   = in_valid;
            assign apx_in = in_apx;
            assign op_a   = in_a[WIDTH-1:K];
            assign op_b   = in_b[WIDTH-1:K];
`ifdef ADD_APX_ERRMON_EN
            assign ex_d   = {1'b0, in_a} + {1'b0, in_b};
`endif
            if (K == 0) begin : g_exact
                assign seg_ci = 1'b0;
                assign sum_d  = SW'(seg);
            end else begin : g_lpo
                logic [K:0]   lo_ex;
                logic [K-1:0] lo_sum;
                assign lo_ex  = {1'b0, in_a[K-1:0]} + {1'b0, in_b[K-1:0]};
                assign lo_sum = in_apx ? (in_a[K-1:0] | in_b[K-1:0]) : lo_ex[K-1:0];
                // The OR part still hands its top-bit generate to the exact part, bounding the error.
                assign seg_ci = in_apx ? (in_a[K-1] & in_b[K-1]) : lo_ex[K];
                assign sum_d  = SW'({seg, lo_sum});
            end
        end else begin : g_body
            assign v_in   = vld_vec[s-1];
            assign apx_in = g_st[s-1].apx_q;
            assign op_a   = g_st[s-1].g_fwd.rem_a_q;
            assign op_b   = g_st[s-1].g_fwd.rem_b_q;
            assign seg_ci = g_st[s-1].g_fwd.cy_q;
            assign sum_d  = SW'({seg, g_st[s-1].sum_q});
`ifdef ADD_APX_ERRMON_EN
            assign ex_d   = g_st[s-1].ex_q;
`endif
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                apx_q <= 1'b0;
                sum_q <= '0;
            end else if (adv[s]) begin
                vld_q <= v_in;
                if (v_in) begin
                    apx_q <= apx_in;
                    sum_q <= sum_d;
                end
            end
        end

`ifdef ADD_APX_ERRMON_EN
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ex_q <= '0;
            end else if (adv[s] && v_in) begin
                ex_q <= ex_d;
            end
        end
`endif

        if (s < S-1) begin : g_fwd
            localparam int RW = WIDTH - LO - W;
            logic [RW-1:0] rem_a_q;
            logic [RW-1:0] rem_b_q;
            logic          cy_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rem_a_q <= '0;
                    rem_b_q <= '0;
                    cy_q    <= 1'b0;
                end else if (adv[s] && v_in) begin
                    rem_a_q <= op_a[WIDTH-LO-1:W];
                    rem_b_q <= op_b[WIDTH-LO-1:W];
                    cy_q    <= seg[W];
                end
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = vld_vec[S-1];
    assign out_sum   = g_st[S-1].sum_q;
    assign out_apx   = g_st[S-1].apx_q;

`ifdef ADD_APX_ERRMON_EN
    logic [WIDTH:0] ex_out;
    logic [WIDTH:0] err_abs;
    logic [WIDTH:0] err_max_q;
    logic [31:0]    err_cnt_q;

    assign ex_out  = g_st[S-1].ex_q;
    assign err_abs = (out_sum >= ex_out) ? (out_sum - ex_out) : (ex_out - out_sum);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_max_q <= '0;
            err_cnt_q <= '0;
        end else if (errmon_clr) begin
            err_max_q <= '0;
            err_cnt_q <= '0;
        end else if (out_valid && out_ready) begin
            if (err_abs > err_max_q) begin
                err_max_q <= err_abs;
            end
            if ((err_abs != '0) && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + 32'd1;
            end
        end
    end

    assign err_max = err_max_q;
    assign err_cnt = err_cnt_q;
`endif

endmodule
